// File: rtl/dbus_wishbone_bridge_if.sv
// Wishbone B4 classic single-master bus bundle between the data-port bridge and its slave.
// Latency: none, wires only.
// Backpressure: the slave throttles the master solely through wb_ack_i.
`timescale 1ns/1ps
interface dbus_wishbone_bridge_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  // Bridge side: drives the cycle, samples read data and acknowledge.
  modport master (
    output wb_adr_o,
    output wb_dat_o,
    output wb_we_o,
    output wb_sel_o,
    output wb_stb_o,
    output wb_cyc_o,
    input  wb_dat_i,
    input  wb_ack_i
  );

  // Slave side: the mirror image of the master view.
  modport slave (
    input  wb_adr_o,
    input  wb_dat_o,
    input  wb_we_o,
    input  wb_sel_o,
    input  wb_stb_o,
    input  wb_cyc_o,
    output wb_dat_i,
    output wb_ack_i
  );
endinterface

// File: rtl/dbus_wishbone_bridge.sv
// CPU data-RAM port to Wishbone B4 classic master bridge, with read-data hold and watchdog.
// Latency: 2 cycles minimum (IDLE issue + BUSY ack); the ack cycle returns read data combinationally.
// Backpressure: stallreq_o holds the pipeline until ack, flush or watchdog expiry; no new request while downstream stalls persist.
`timescale 1ns/1ps
module dbus_wishbone_bridge #(
  // BUSY cycles without ack before abort; 0 disables the watchdog. Usable range 0..65535.
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall_i,
  input  logic                   flush_i,
  input  logic                   cpu_ce_i,
  input  logic                   cpu_we_i,
  input  logic [31:0]            cpu_addr_i,
  input  logic [31:0]            cpu_data_i,
  input  logic [3:0]             cpu_sel_i,
  output logic [31:0]            cpu_data_o,
  output logic                   stallreq_o,
  output logic                   err_o,
  dbus_wishbone_bridge_if.master wb
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_BUSY       = 2'd1;
  localparam logic [1:0] ST_WAIT_STALL = 2'd2;

  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  // Count value seen in the last BUSY cycle the slave is allowed before abort.
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [1:0]  state_q,     state_d;
  logic [31:0] wb_adr_q,    wb_adr_d;
  logic [31:0] wb_dat_q,    wb_dat_d;
  logic        wb_we_q,     wb_we_d;
  logic [3:0]  wb_sel_q,    wb_sel_d;
  logic        wb_cyc_q,    wb_cyc_d;
  logic [31:0] rd_buf_q,    rd_buf_d;
  logic [15:0] tmo_cnt_q,   tmo_cnt_d;
  logic        err_q,       err_d;

  logic        bus_drop;
  logic        tmo_hit;
  logic        stallreq_c;
  logic [31:0] cpu_data_c;

  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  // Next-state, bus register and combinational CPU-side response logic.
  always_comb begin
    state_d    = state_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    wb_we_d    = wb_we_q;
    wb_sel_d   = wb_sel_q;
    wb_cyc_d   = wb_cyc_q;
    rd_buf_d   = rd_buf_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = 1'b0;
    bus_drop   = 1'b0;
    stallreq_c = 1'b0;
    cpu_data_c = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          wb_adr_d   = cpu_addr_i;
          wb_dat_d   = cpu_data_i;
          wb_we_d    = cpu_we_i;
          wb_sel_d   = cpu_sel_i;
          wb_cyc_d   = 1'b1;
          tmo_cnt_d  = 16'd0;
          rd_buf_d   = 32'd0;
          state_d    = ST_BUSY;
          stallreq_c = 1'b1;
        end
      end

      ST_BUSY: begin
        if (flush_i) begin
          // A coincident ack is dropped; a write may already be committed at the slave.
          bus_drop = 1'b1;
          rd_buf_d = 32'd0;
          state_d  = ST_IDLE;
        end else if (wb.wb_ack_i) begin
          bus_drop = 1'b1;
          if (!wb_we_q) begin
            rd_buf_d   = wb.wb_dat_i;
            cpu_data_c = wb.wb_dat_i;
          end
          state_d = (stall_i != 6'd0) ? ST_WAIT_STALL : ST_IDLE;
        end else if (tmo_hit) begin
          bus_drop = 1'b1;
          rd_buf_d = 32'd0;
          err_d    = 1'b1;
          state_d  = (stall_i != 6'd0) ? ST_WAIT_STALL : ST_IDLE;
        end else begin
          tmo_cnt_d  = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
          stallreq_c = 1'b1;
        end
      end

      ST_WAIT_STALL: begin
        // Another stage still stalls: keep presenting the captured data to MEM.
        cpu_data_c = rd_buf_q;
        if (flush_i) begin
          rd_buf_d = 32'd0;
          state_d  = ST_IDLE;
        end else if (stall_i == 6'd0) begin
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus_drop) begin
      wb_adr_d = 32'd0;
      wb_dat_d = 32'd0;
      wb_we_d  = 1'b0;
      wb_sel_d = 4'd0;
      wb_cyc_d = 1'b0;
    end
  end

  // State and registered bus outputs; reset clears everything without waiting for the slave.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wb_adr_q  <= 32'd0;
      wb_dat_q  <= 32'd0;
      wb_we_q   <= 1'b0;
      wb_sel_q  <= 4'd0;
      wb_cyc_q  <= 1'b0;
      rd_buf_q  <= 32'd0;
      tmo_cnt_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_adr_q  <= wb_adr_d;
      wb_dat_q  <= wb_dat_d;
      wb_we_q   <= wb_we_d;
      wb_sel_q  <= wb_sel_d;
      wb_cyc_q  <= wb_cyc_d;
      rd_buf_q  <= rd_buf_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  // Combinational CPU outputs are forced low while reset is held, even with ce asserted.
  assign stallreq_o  = rst & stallreq_c;
  assign cpu_data_o  = rst ? cpu_data_c : 32'd0;
  assign err_o       = err_q;

  // Classic single cycles: strobe and cycle always move together.
  assign wb.wb_adr_o = wb_adr_q;
  assign wb.wb_dat_o = wb_dat_q;
  assign wb.wb_we_o  = wb_we_q;
  assign wb.wb_sel_o = wb_sel_q;
  assign wb.wb_cyc_o = wb_cyc_q;
  assign wb.wb_stb_o = wb_cyc_q;

endmodule

// File: tb/tb_dbus_wishbone_bridge.sv
// Self-checking bench for dbus_wishbone_bridge: scoreboard of per-access expectations.
// Latency: stimulus pushes the expected outcome before issuing; a monitor pops it on the first BUSY cycle.
// Backpressure: slave ack delay, flush and downstream stall hold are randomized per access.
`timescale 1ns/1ps
module tb_dbus_wishbone_bridge;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          fin;
    int          hold;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, ce, we;
  logic [31:0] addr, wdat, cpu_data;
  logic [3:0]  sel;
  logic        stallreq, err;

  logic [5:0]  nt_stall;
  logic        nt_flush, nt_ce, nt_we;
  logic [31:0] nt_addr, nt_wdat, nt_cpu_data;
  logic [3:0]  nt_sel;
  logic        nt_stallreq, nt_err;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_on   = 1'b1;
  bit   mon_busy = 1'b0;

  dbus_wishbone_bridge_if wb_if ();
  dbus_wishbone_bridge_if nt_if ();

  dbus_wishbone_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_data_i(wdat),
    .cpu_sel_i(sel), .cpu_data_o(cpu_data), .stallreq_o(stallreq),
    .err_o(err), .wb(wb_if)
  );

  dbus_wishbone_bridge #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst(rst), .stall_i(nt_stall), .flush_i(nt_flush),
    .cpu_ce_i(nt_ce), .cpu_we_i(nt_we), .cpu_addr_i(nt_addr), .cpu_data_i(nt_wdat),
    .cpu_sel_i(nt_sel), .cpu_data_o(nt_cpu_data), .stallreq_o(nt_stallreq),
    .err_o(nt_err), .wb(nt_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // One access: outcome is derived from the first event among flush, ack and watchdog
  // (flush beats ack beats watchdog when they coincide), then the bus is driven to match.
  task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                        input logic [3:0] t_sel, input logic [31:0] t_rd, input int ackc,
                        input int flc, input int hold, input int gap, input logic [5:0] spat);
    exp_t e;
    int fin;
    logic [5:0] pat;
    fin = TMO;
    if (ackc > 0 && ackc <= fin) fin = ackc;
    if (flc > 0 && flc <= fin) fin = flc;
    e.adr = t_adr; e.dat = t_dat; e.sel = t_sel; e.we = t_we; e.fin = fin; e.hold = hold;
    if (flc == fin) begin
      e.rdata = 32'd0; e.err = 1'b0; e.hold = 0;
    end else if (ackc == fin) begin
      e.rdata = t_we ? 32'd0 : t_rd; e.err = 1'b0;
    end else begin
      e.rdata = 32'd0; e.err = 1'b1;
    end
    exp_q.push_back(e);
    pat = (spat != 6'd0) ? spat : 6'($urandom_range(1, 63));

    ce = 1'b1; we = t_we; addr = t_adr; wdat = t_dat; sel = t_sel;
    stall = 6'd0; flush = 1'b0; wb_if.wb_ack_i = 1'b0; wb_if.wb_dat_i = $urandom;
    @(posedge clk); #1;
    for (int k = 1; k <= fin; k++) begin
      wb_if.wb_ack_i = (k == ackc);
      flush          = (k == flc);
      wb_if.wb_dat_i = (k == ackc) ? t_rd : $urandom;
      stall          = (k == fin && e.hold > 0) ? pat : 6'd0;
      @(posedge clk); #1;
    end
    wb_if.wb_ack_i = 1'b0; flush = 1'b0; ce = 1'b0;
    // Downstream stall hold; ce stays up to probe that nothing is issued meanwhile.
    for (int j = 1; j <= e.hold; j++) begin
      stall = (j < e.hold) ? pat : 6'd0;
      ce    = 1'b1;
      addr  = $urandom;
      @(posedge clk); #1;
    end
    ce = 1'b0; stall = 6'd0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pairs each observed bus cycle with the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   cnt;
    logic pre_sr;
    forever begin
      do begin
        pre_sr = stallreq;
        @(negedge clk);
      end while (!(wb_if.wb_cyc_o && mon_on));
      mon_busy = 1'b1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_cycle: got cyc with adr 0x%08h, want no cycle", wb_if.wb_adr_o);
        for (int w = 0; w < 64 && wb_if.wb_cyc_o; w++) @(negedge clk);
      end else begin
        e = exp_q.pop_front();
        chk("issue_stallreq", 32'(pre_sr), 32'd1);
        chk("wb_adr", wb_if.wb_adr_o, e.adr);
        chk("wb_dat", wb_if.wb_dat_o, e.dat);
        chk("wb_sel", 32'(wb_if.wb_sel_o), 32'(e.sel));
        chk("wb_we", 32'(wb_if.wb_we_o), 32'(e.we));
        chk("wb_stb", 32'(wb_if.wb_stb_o), 32'd1);
        cnt = 0;
        while (stallreq && cnt < 64) begin
          cnt++;
          @(negedge clk);
        end
        chk("busy_stall_cycles", 32'(cnt), 32'(e.fin - 1));
        chk("cyc_at_done", 32'(wb_if.wb_cyc_o), 32'd1);
        chk("done_data", cpu_data, e.rdata);
        for (int j = 1; j <= ((e.hold > 0) ? e.hold : 1); j++) begin
          @(negedge clk);
          if (j == 1) chk("err_after_done", 32'(err), 32'(e.err));
          else        chk("err_pulse_width", 32'(err), 32'd0);
          chk("cyc_after_done", 32'(wb_if.wb_cyc_o), 32'd0);
          if (e.hold > 0) begin
            chk("wait_data", cpu_data, e.rdata);
            chk("wait_stallreq", 32'(stallreq), 32'd0);
          end
        end
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish before 2ms");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    rst = 1'b0; stall = 6'd0; flush = 1'b0; ce = 1'b1; we = 1'b0;
    addr = 32'd0; wdat = 32'd0; sel = 4'd0;
    wb_if.wb_ack_i = 1'b0; wb_if.wb_dat_i = 32'd0;
    nt_stall = 6'd0; nt_flush = 1'b0; nt_ce = 1'b0; nt_we = 1'b0;
    nt_addr = 32'd0; nt_wdat = 32'd0; nt_sel = 4'd0;
    nt_if.wb_ack_i = 1'b0; nt_if.wb_dat_i = 32'd0;

    // Reset state, with ce held high to show the stall request is masked.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_cpu_data", cpu_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cyc", 32'(wb_if.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_if.wb_stb_o), 32'd0);
    chk("rst_adr", wb_if.wb_adr_o, 32'd0);
    chk("rst_dat", wb_if.wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_if.wb_sel_o), 32'd0);
    chk("rst_we", 32'(wb_if.wb_we_o), 32'd0);
    ce = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan, then randomized traffic.
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEADBEEF, 4, 0, 0, 0, 6'd0);
    do_txn(1'b1, 32'h0000_0020, 32'h12345678, 4'h3, $urandom, 1, 0, 0, 1, 6'd0);
    do_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 32'hA5A5A5A5, 2, 0, 2, 0, 6'b001111);
    do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h11111111, 0, 2, 1, 1, 6'd0);
    do_txn(1'b0, 32'h0000_0044, 32'h0, 4'hF, 32'h22222222, 3, 3, 1, 0, 6'd0);
    do_txn(1'b0, 32'h0000_0050, 32'h0, 4'hF, 32'h33333333, 0, 0, 2, 1, 6'd0);
    do_txn(1'b1, 32'h0000_0054, 32'h44444444, 4'hC, $urandom, 0, 0, 0, 0, 6'd0);
    for (int n = 0; n < 150; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
             $urandom, int'($urandom_range(0, 6)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 6'd0);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 32'(exp_q.size()) + 32'(mon_busy), 32'd0);

    // Asynchronous reset in the middle of a BUSY access.
    mon_on = 1'b0;
    ce = 1'b1; we = 1'b0; addr = 32'h60; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_arst_cyc", 32'(wb_if.wb_cyc_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_if.wb_cyc_o), 32'd0);
    chk("arst_stb", 32'(wb_if.wb_stb_o), 32'd0);
    chk("arst_stallreq", 32'(stallreq), 32'd0);
    chk("arst_cpu_data", cpu_data, 32'd0);
    @(posedge clk); #1;
    chk("arst_hold_stallreq", 32'(stallreq), 32'd0);
    ce = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b1; addr = 32'h44; wdat = 32'hCAFEF00D; sel = 4'hF;
    #1;
    chk("post_arst_req", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    chk("post_arst_cyc", 32'(wb_if.wb_cyc_o), 32'd1);
    chk("post_arst_adr", wb_if.wb_adr_o, 32'h44);
    chk("post_arst_dat", wb_if.wb_dat_o, 32'hCAFEF00D);
    chk("post_arst_we", 32'(wb_if.wb_we_o), 32'd1);
    wb_if.wb_ack_i = 1'b1; wb_if.wb_dat_i = 32'h5555AAAA;
    #1;
    chk("post_arst_ack_stallreq", 32'(stallreq), 32'd0);
    chk("post_arst_ack_data", cpu_data, 32'd0);
    @(posedge clk); #1;
    wb_if.wb_ack_i = 1'b0; ce = 1'b0;
    chk("post_arst_cyc_drop", 32'(wb_if.wb_cyc_o), 32'd0);
    chk("post_arst_err", 32'(err), 32'd0);

    // Watchdog disabled: a silent slave keeps the access BUSY indefinitely.
    nt_ce = 1'b1; nt_we = 1'b0; nt_addr = 32'h80; nt_sel = 4'hF;
    @(posedge clk); #1;
    for (int i = 1; i <= 300; i++) begin
      if (i % 60 == 0) begin
        chk("nt_busy_stallreq", 32'(nt_stallreq), 32'd1);
        chk("nt_busy_cyc", 32'(nt_if.wb_cyc_o), 32'd1);
        chk("nt_busy_err", 32'(nt_err), 32'd0);
      end
      @(posedge clk); #1;
    end
    nt_if.wb_dat_i = 32'h0BADF00D; nt_if.wb_ack_i = 1'b1;
    #1;
    chk("nt_ack_stallreq", 32'(nt_stallreq), 32'd0);
    chk("nt_ack_data", nt_cpu_data, 32'h0BADF00D);
    @(posedge clk); #1;
    nt_if.wb_ack_i = 1'b0; nt_ce = 1'b0;
    chk("nt_cyc_drop", 32'(nt_if.wb_cyc_o), 32'd0);
    chk("nt_err", 32'(nt_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
